// File: rtl/regbank_pkg.sv
// Shared definitions for the regbank_mp register bank.
//  - Default geometry (data width, register count, read-port count).
//  - Write-mode encodings driven on wr_mode by writeback.
package regbank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 16;
  localparam int DEF_NRD    = 2;

  localparam logic [1:0] WR_FULL = 2'b00;  // whole word from wr_data
  localparam logic [1:0] WR_HIGH = 2'b01;  // wr_data low half -> upper half, lower kept
  localparam logic [1:0] WR_LOW  = 2'b10;  // wr_data low half -> lower half, upper kept
  localparam logic [1:0] WR_MEM  = 2'b11;  // whole word from mem_q

endpackage

// File: rtl/regbank_merge.sv
// Combinational write-merge for the register bank.
// Ports:
//  old_val  in  DATA_W  current contents of the destination register
//  wr_data  in  DATA_W  ALU result (only its low half is used in half modes)
//  mem_q    in  DATA_W  memory load data
//  wr_mode  in  2       WR_FULL / WR_HIGH / WR_LOW / WR_MEM
//  new_val  out DATA_W  value the register takes after the write
module regbank_merge
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_q,
  input  logic [1:0]        wr_mode,
  output logic [DATA_W-1:0] new_val
);

  localparam int HALF = DATA_W / 2;

  always_comb begin
    new_val = old_val;
    case (wr_mode)
      WR_FULL: new_val = wr_data;
      WR_HIGH: new_val = {wr_data[HALF-1:0], old_val[HALF-1:0]};
      WR_LOW:  new_val = {old_val[DATA_W-1:HALF], wr_data[HALF-1:0]};
      default: new_val = mem_q;
    endcase
  end

endmodule

// File: rtl/regbank_mp.sv
// Multi-port CPU register bank with write->read bypass and a pending-write
// scoreboard. Register 0 reads as zero and can never be written or reserved.
// Ports:
//  clk       in   1            rising-edge clock
//  reset     in   1            asynchronous, active-low reset
//  rd_en     in   1            capture all read ports this edge
//  rd_addr   in   NRD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data   out  NRD*DATA_W   registered read data, port k at [k*DATA_W +: DATA_W]
//  rd_busy   out  NRD          source of port k had a pending write when captured
//  wr_en     in   1            write this edge
//  wr_addr   in   ADDR_W       write destination
//  wr_mode   in   2            WR_FULL / WR_HIGH / WR_LOW / WR_MEM
//  wr_data   in   DATA_W       ALU result
//  mem_q     in   DATA_W       memory load data
//  rsv_en    in   1            reserve rsv_addr (mark pending)
//  rsv_addr  in   ADDR_W       register to reserve
//  sb_busy   out  NREGS        scoreboard vector, bit 0 always 0
module regbank_mp
  import regbank_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NRD    = DEF_NRD,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [1:0]            wr_mode,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W-1:0]     mem_q,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [NREGS-1:0]      sb_busy
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wr_merged;
  logic [NREGS-1:0]  sb_next;
  logic [DATA_W-1:0] rd_data_p1 [NRD];
  logic              rd_busy_p1 [NRD];

  // Single merge instance; the bypass path reuses its result.
  regbank_merge #(.DATA_W(DATA_W)) u_merge (
    .old_val (regs[wr_addr]),
    .wr_data (wr_data),
    .mem_q   (mem_q),
    .wr_mode (wr_mode),
    .new_val (wr_merged)
  );

  // Register array: entry 0 is reset to zero and never written afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_merged;
    end
  end

  // Reservation is applied after the writeback clear so a same-edge
  // reserve of the register being written back stays pending.
  always_comb begin
    sb_next = sb_busy;
    if (wr_en)  sb_next[wr_addr]  = 1'b0;
    if (rsv_en) sb_next[rsv_addr] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sb_busy <= '0;
    else        sb_busy <= sb_next;
  end

  // Read ports: p0 is the address/bypass decision, p1 the captured outputs.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_p0;
    logic              hit_p0;

    assign addr_p0 = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit_p0  = wr_en && (wr_addr == addr_p0);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_data_p1[k] <= '0;
        rd_busy_p1[k] <= 1'b0;
      end else if (rd_en) begin
        if (addr_p0 == '0) begin
          rd_data_p1[k] <= '0;
          rd_busy_p1[k] <= 1'b0;
        end else begin
          rd_data_p1[k] <= hit_p0 ? wr_merged : regs[addr_p0];
          rd_busy_p1[k] <= sb_busy[addr_p0] & ~hit_p0;
        end
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd_data_p1[k];
    assign rd_busy[k]                  = rd_busy_p1[k];
  end

endmodule
